// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin grant controller.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StTmo,
    StDrain
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: optional priority master, else first requester after ptr.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUMM = 3,
  localparam int unsigned IW = clog2_min1(NUMM),
  localparam int unsigned HW = clog2_min1(NUMM + 1)
) (
  input  logic [NUMM-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [HW-1:0]   hipri,
  output logic [NUMM-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] cand;
  logic          found;

  assign any = |req;

  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if ((32'(hipri) < NUMM) && req[hipri[IW-1:0]]) begin
      win_idx = hipri[IW-1:0];
      found   = 1'b1;
    end else begin
      // Search starts just after ptr; i == NUMM lands back on ptr itself.
      for (int unsigned i = 1; i <= NUMM; i++) begin
        cand = IW'((32'(ptr) + i) % NUMM);
        if (!found && req[cand]) begin
          win_idx = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int unsigned i = 0; i < NUMM; i++) begin
      win_oh[i] = found && (32'(win_idx) == i);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone shared-bus grant controller: round-robin with optional priority master and a
// watchdog that turns a stalled transfer into a one-cycle error.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUMM    = 3,
  parameter int unsigned HIPRI   = 0,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 8,
  localparam int unsigned IW = clog2_min1(NUMM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NUMM-1:0] cyc_i,
  input  logic [NUMM-1:0] stb_i,
  input  logic            ack_i,
  input  logic            err_i,
  output logic [NUMM-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_vld_o,
  output logic            stb_mask_o,
  output logic            tmo_err_o,
  output logic [CNTW-1:0] tmo_cnt_o
);

  localparam int unsigned HW = clog2_min1(NUMM + 1);
  localparam int unsigned WW = clog2_min1(TIMEOUT + 1);
  localparam logic [HW-1:0] HipriL = HW'(HIPRI);
  localparam logic [IW-1:0] PtrRst = IW'(NUMM - 1);

  arb_state_e      state_q, state_d;
  logic [NUMM-1:0] gnt_q;
  logic [IW-1:0]   gnt_idx_q;
  logic            gnt_vld_q;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [CNTW-1:0] tmo_cnt_q;

  logic            load, drop, rel, wait_cyc, tmo_hit;
  logic [NUMM-1:0] pick_req, pick_oh;
  logic [IW-1:0]   pick_ptr, pick_idx;
  logic            pick_any;

  // The current holder is masked so a handover only considers the other masters.
  assign pick_req = cyc_i & ~gnt_q;
  assign pick_ptr = (state_q == StIdle) ? ptr_q : gnt_idx_q;

  rr_pick #(
    .NUMM (NUMM)
  ) u_pick (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .hipri   (HipriL),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign rel      = gnt_vld_q && !cyc_i[gnt_idx_q];
  assign wait_cyc = stb_i[gnt_idx_q] && !ack_i && !err_i;
  assign tmo_hit  = (TIMEOUT != 0) && wait_cyc && ((32'(wdog_q) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          load    = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy, StDrain: begin
        if (rel) begin
          ptr_d = gnt_idx_q;
          if (pick_any) begin
            load    = 1'b1;
            state_d = StBusy;
          end else begin
            drop    = 1'b1;
            state_d = StIdle;
          end
        end else if ((state_q == StBusy) && tmo_hit) begin
          state_d = StTmo;
        end
      end
      StTmo:   state_d = StDrain;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wdog_d = wdog_q;
    if (load || ack_i || err_i) begin
      wdog_d = '0;
    end else if ((state_q == StBusy) && stb_i[gnt_idx_q]) begin
      wdog_d = wdog_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= PtrRst;
      wdog_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wdog_q <= wdog_d;
      if (load) begin
        gnt_q     <= pick_oh;
        gnt_idx_q <= pick_idx;
        gnt_vld_q <= 1'b1;
      end else if (drop) begin
        gnt_q     <= '0;
        gnt_idx_q <= '0;
        gnt_vld_q <= 1'b0;
      end
      if ((state_q == StTmo) && !(&tmo_cnt_q)) begin
        tmo_cnt_q <= tmo_cnt_q + CNTW'(1);
      end
    end
  end

  always_comb begin
    gnt_o      = gnt_q;
    gnt_idx_o  = gnt_idx_q;
    gnt_vld_o  = gnt_vld_q;
    stb_mask_o = (state_q == StTmo) || (state_q == StDrain);
    tmo_err_o  = (state_q == StTmo);
    tmo_cnt_o  = tmo_cnt_q;
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
  a_consistent: assert property (@(posedge clk) disable iff (rst)
    gnt_o == (NUMM'(gnt_vld_o) << gnt_idx_o));
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (gnt_vld_o && cyc_i[gnt_idx_o]) |=> $stable(gnt_o));
  a_tmo_pulse: assert property (@(posedge clk) disable iff (rst) tmo_err_o |=> !tmo_err_o);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: a pure round-robin instance driven from a vector table, plus a priority
// instance and hand-written sequences for saturation and reset-in-drain.
module tb_wb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cyc = '0;
  logic [2:0] stb = '0;
  logic       ack = 1'b0;
  logic       err = 1'b0;

  logic [2:0] gnt, h_gnt, cnt, h_cnt;
  logic [1:0] idx, h_idx;
  logic       vld, mask, tmo, h_vld, h_mask, h_tmo;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUMM    (3),
    .HIPRI   (3),
    .TIMEOUT (4),
    .CNTW    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .ack_i      (ack),
    .err_i      (err),
    .gnt_o      (gnt),
    .gnt_idx_o  (idx),
    .gnt_vld_o  (vld),
    .stb_mask_o (mask),
    .tmo_err_o  (tmo),
    .tmo_cnt_o  (cnt)
  );

  wb_rr_arbiter #(
    .NUMM    (3),
    .HIPRI   (0),
    .TIMEOUT (4),
    .CNTW    (3)
  ) dut_hp (
    .clk        (clk),
    .rst        (rst),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .ack_i      (ack),
    .err_i      (err),
    .gnt_o      (h_gnt),
    .gnt_idx_o  (h_idx),
    .gnt_vld_o  (h_vld),
    .stb_mask_o (h_mask),
    .tmo_err_o  (h_tmo),
    .tmo_cnt_o  (h_cnt)
  );

  typedef struct {
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack;
    logic       err;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       mask;
    logic       tmo;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [2:0] s, input logic a,
                              input logic e, input logic [2:0] g, input logic [1:0] i,
                              input logic v, input logic m, input logic t,
                              input logic [2:0] n);
    vec_t r;
    r.cyc = c; r.stb = s; r.ack = a; r.err = e;
    r.gnt = g; r.idx = i; r.vld = v; r.mask = m; r.tmo = t; r.cnt = n;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input logic [2:0] c, input logic [2:0] s, input logic a, input logic e);
    cyc = c; stb = s; ack = a; err = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;

    // Grant handover, round-robin order, watchdog timeout / response-wins / stb-low hold.
    vecs.push_back(mk(3'b110, 3'b000, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b110, 3'b000, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 0, 3'd0));
    vecs.push_back(mk(3'b111, 3'b000, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b111, 3'b001, 1, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b110, 3'b000, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b111, 3'b010, 1, 0, 3'b010, 2'd1, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b101, 3'b000, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b111, 3'b100, 1, 0, 3'b100, 2'd2, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b011, 3'b000, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b111, 3'b001, 1, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b110, 3'b000, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 0, 3'd0));
    vecs.push_back(mk(3'b001, 3'b000, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b001, 2'd0, 1, 0, 0, 3'd0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b001, 2'd0, 1, 1, 1, 3'd0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b001, 2'd0, 1, 1, 0, 3'd1));
    vecs.push_back(mk(3'b001, 3'b001, 1, 0, 3'b001, 2'd0, 1, 1, 0, 3'd1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b010, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b010, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b010, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b010, 1, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b010, 3'b010, 0, 0, 3'b010, 2'd1, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b100, 2'd2, 1, 0, 0, 3'd1));
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 1, 1, 1, 3'd1));
    vecs.push_back(mk(3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 1, 1, 0, 3'd2));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 0, 3'd2));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_main", {21'd0, gnt, idx, vld, mask, tmo, cnt}, 32'd0);
    check("reset_hp", {21'd0, h_gnt, h_idx, h_vld, h_mask, h_tmo, h_cnt}, 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].cyc, vecs[k].stb, vecs[k].ack, vecs[k].err);
      check($sformatf("vec%0d", k), {21'd0, gnt, idx, vld, mask, tmo, cnt},
            {21'd0, vecs[k].gnt, vecs[k].idx, vecs[k].vld, vecs[k].mask, vecs[k].tmo,
             vecs[k].cnt});
    end

    // Nine more timeouts on top of the two above: counter must stop at 7.
    for (int k = 0; k < 9; k++) begin
      seen = 1'b0;
      cyc = 3'b001; stb = 3'b001; ack = 1'b0; err = 1'b0;
      for (int w = 0; w < 12 && !seen; w++) begin
        @(posedge clk);
        #1;
        if (tmo) seen = 1'b1;
      end
      check($sformatf("tmo_pulse%0d", k), 32'(seen), 32'd1);
      cyc = 3'b000; stb = 3'b000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      if (k == 3) check("tmo_cnt_6", 32'(cnt), 32'd6);
    end
    check("tmo_cnt_sat", 32'(cnt), 32'd7);
    check("sat_idle", 32'(vld), 32'd0);

    // Priority master wins arbitration points but never preempts.
    step(3'b000, 3'b000, 0, 0);
    rst = 1'b1;
    step(3'b000, 3'b000, 0, 0);
    check("reset2_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    step(3'b010, 3'b000, 0, 0);
    check("hp_first", 32'(h_gnt), 32'b010);
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 3'b000, 0, 0);
      check($sformatf("hp_hold%0d", k), 32'(h_gnt), 32'b010);
    end
    step(3'b101, 3'b000, 0, 0);
    check("hp_pri_win", 32'(h_gnt), 32'b001);
    check("rr_no_pri", 32'(gnt), 32'b100);
    step(3'b111, 3'b000, 0, 0);
    check("hp_pri_hold", 32'(h_gnt), 32'b001);
    check("rr_hold", 32'(gnt), 32'b100);
    step(3'b110, 3'b000, 0, 0);
    check("hp_others_in", {27'd0, h_gnt, h_idx}, {27'd0, 3'b010, 2'd1});
    step(3'b101, 3'b000, 0, 0);
    check("hp_rewin", {27'd0, h_gnt, h_idx}, {27'd0, 3'b001, 2'd0});
    step(3'b000, 3'b000, 0, 0);
    check("hp_idle", 32'(h_vld), 32'd0);

    // Reset while draining after a timeout.
    cyc = 3'b111; stb = 3'b111; ack = 1'b0; err = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(posedge clk);
      #1;
      if (mask && !tmo) seen = 1'b1;
    end
    check("reach_drain", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_drain", {21'd0, gnt, idx, vld, mask, tmo, cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_grant", {26'd0, gnt, idx, vld}, {26'd0, 3'b001, 2'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
